// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage (NB = 4, 6 or 8 columns) with a 2-entry skid buffer.
// Optional feature: define SHIFT_ROWS_PIPE_COUNT_EN to add the 32-bit blk_count emit counter port.
module shift_rows_pipe #(
  parameter int unsigned NB = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inverse,
  input  logic [0:32*NB-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:32*NB-1] out_data
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
  ,
  output logic [31:0]      blk_count
`endif
);

  localparam int unsigned W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
  end

  function automatic int unsigned row_off(int unsigned r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [0:W-1] fwd;
  logic [0:W-1] inv;
  logic [0:W-1] shifted;

  // Source columns are constants, so the row rotation is pure wiring.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned FS = (int'(c) + row_off(r)) % NB;
      localparam int unsigned IS = (int'(c) + NB - row_off(r)) % NB;
      assign fwd[8*(4*c+r) +: 8] = in_data[8*(4*FS+r) +: 8];
      assign inv[8*(4*c+r) +: 8] = in_data[8*(4*IS+r) +: 8];
    end
  end

  assign shifted = in_inverse ? inv : fwd;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e       state_q;
  logic [0:W-1] skid_q;
  logic         accept;
  logic         emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StEmpty;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_q    <= '0;
    end else if (clear) begin
      state_q   <= StEmpty;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_data  <= shifted;
            state_q   <= StOne;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        StOne: begin
          if (accept && !emit) begin
            skid_q   <= shifted;
            state_q  <= StTwo;
            in_ready <= 1'b0;
          end else if (accept && emit) begin
            out_data <= shifted;
          end else if (emit) begin
            state_q   <= StEmpty;
            out_valid <= 1'b0;
          end
        end
        StTwo: begin
          if (emit) begin
            out_data <= skid_q;
            state_q  <= StOne;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= StEmpty;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SHIFT_ROWS_PIPE_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (emit) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB = 4, 6 and 8 instances share one handshake,
// checked against a byte-level reference of the row rotation and a FIFO scoreboard.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_inverse = 1'b0;
  logic out_ready = 1'b0;
  logic [0:255] d4 = '0;
  logic [0:255] d6 = '0;
  logic [0:255] d8 = '0;
  logic [0:127] o4;
  logic [0:191] o6;
  logic [0:255] o8;
  logic [0:255] o4w;
  logic [0:255] o6w;
  logic rdy4, rdy6, rdy8, vld4, vld6, vld8;
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
  logic [31:0] cnt4, cnt6, cnt8;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [0:255] e4;
    logic [0:255] e6;
    logic [0:255] e8;
  } exp_t;
  exp_t q[$];

  assign o4w = {o4, 128'h0};
  assign o6w = {o6, 64'h0};

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy4),
    .in_inverse(in_inverse), .in_data(d4[0:127]), .out_valid(vld4), .out_ready(out_ready),
    .out_data(o4)
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
    , .blk_count(cnt4)
`endif
  );

  shift_rows_pipe #(.NB(6)) dut6 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy6),
    .in_inverse(in_inverse), .in_data(d6[0:191]), .out_valid(vld6), .out_ready(out_ready),
    .out_data(o6)
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
    , .blk_count(cnt6)
`endif
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy8),
    .in_inverse(in_inverse), .in_data(d8), .out_valid(vld8), .out_ready(out_ready),
    .out_data(o8)
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
    , .blk_count(cnt8)
`endif
  );

  // Upstream protocol: a stalled offer must stay put until taken.
  assert property (@(posedge clk) disable iff (!n_rst)
      (in_valid && !rdy4 && !clear) |=> (in_valid && $stable(d4) && $stable(d6) &&
                                         $stable(d8) && $stable(in_inverse)))
    else begin
      n_err++;
      $display("FAIL upstream_hold: in_valid/in_data changed while stalled");
    end

  // Reference: out(r,c) = in(r,(c+s) mod nb) forward, in(r,(c-s) mod nb) inverse.
  function automatic logic [0:255] ref_shift(int nb, logic [0:255] d, bit inv);
    logic [0:255] o;
    int s;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        o[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:255] rand_blk();
    logic [0:255] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_exp(logic [0:255] d, bit inv);
    exp_t e;
    e.e4 = ref_shift(4, d, inv);
    e.e6 = ref_shift(6, d, inv);
    e.e8 = ref_shift(8, d, inv);
    q.push_back(e);
  endtask

  task automatic set_all(logic [0:255] d);
    d4 = d;
    d6 = d;
    d8 = d;
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    @(negedge clk);
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL rst_valid4: got %b want 0", vld4); end
    n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL rst_ready4: got %b want 1", rdy4); end
    n_vec++; if (o4 !== '0) begin n_err++; $display("FAIL rst_data4: got %h want 0", o4); end
    n_vec++; if (vld8 !== 1'b0) begin n_err++; $display("FAIL rst_valid8: got %b want 0", vld8); end
    n_vec++; if (o8 !== '0) begin n_err++; $display("FAIL rst_data8: got %h want 0", o8); end
    n_rst = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", rdy4); end
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", vld4); end
  endtask

  task automatic test_fips();
    d4 = {128'hd42711aee0bf98f1b8b45de51e415230, 128'h0};
    in_inverse = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (vld4 !== 1'b1) begin n_err++; $display("FAIL fips_valid: got %b want 1", vld4); end
    n_vec++;
    if (o4 !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      n_err++; $display("FAIL fips_data: got %h want d4bf5d30e0b452aeb84111f11e2798e5", o4);
    end
    @(negedge clk);
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL fips_drain: got %b want 0", vld4); end
  endtask

  task automatic test_round_trip();
    logic [0:255] id4, id6, id8, e;
    int unsigned r2col[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    int unsigned r3col[8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    id4 = '0; id6 = '0; id8 = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < 16) id4[8*k +: 8] = 8'(k);
      if (k < 24) id6[8*k +: 8] = 8'(k);
      id8[8*k +: 8] = 8'(k);
    end
    d4 = id4; d6 = id6; d8 = id8;
    in_inverse = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (o4 !== 128'h00050a0f04090e03080d02070c01060b) begin
      n_err++; $display("FAIL fwd_nb4: got %h want 00050a0f04090e03080d02070c01060b", o4);
    end
    for (int c = 0; c < 8; c++) begin
      n_vec++;
      if (o8[8*(4*c+2) +: 8] !== 8'(4*r2col[c]+2)) begin
        n_err++; $display("FAIL fwd_nb8_row2 col%0d: got %h want %h", c, o8[8*(4*c+2) +: 8],
                          8'(4*r2col[c]+2));
      end
      n_vec++;
      if (o8[8*(4*c+3) +: 8] !== 8'(4*r3col[c]+3)) begin
        n_err++; $display("FAIL fwd_nb8_row3 col%0d: got %h want %h", c, o8[8*(4*c+3) +: 8],
                          8'(4*r3col[c]+3));
      end
    end
    e = ref_shift(6, id6, 1'b0);
    n_vec++; if (o6w !== e) begin n_err++; $display("FAIL fwd_nb6: got %h want %h", o6w, e); end
    // Feed each forward result back through the inverse.
    d4 = o4w; d6 = o6w; d8 = o8;
    in_inverse = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (o4w !== id4) begin n_err++; $display("FAIL inv_nb4: got %h want %h", o4w, id4); end
    n_vec++; if (o6w !== id6) begin n_err++; $display("FAIL inv_nb6: got %h want %h", o6w, id6); end
    n_vec++; if (o8 !== id8) begin n_err++; $display("FAIL inv_nb8: got %h want %h", o8, id8); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [0:255] bp[5];
    bit bpi[5];
    int i = 0;
    int emitted = 0;
    exp_t e;
    q.delete();
    for (int k = 0; k < 5; k++) begin bp[k] = rand_blk(); bpi[k] = 1'($urandom_range(0, 1)); end
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      set_all(bp[i]); in_inverse = bpi[i]; in_valid = 1'b1;
      #1;
      if (cyc >= 2) begin
        e = q[0];
        n_vec++;
        if (vld4 !== 1'b1 || o4w !== e.e4) begin
          n_err++; $display("FAIL bp_stall_hold: valid %b data %h want 1 %h", vld4, o4w, e.e4);
        end
      end
      if (rdy4) begin push_exp(bp[i], bpi[i]); i++; end
    end
    n_vec++; if (i !== 2) begin n_err++; $display("FAIL bp_accepts: got %0d want 2", i); end
    n_vec++; if (rdy4 !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", rdy4); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (i < 5) begin set_all(bp[i]); in_inverse = bpi[i]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      n_vec++;
      if (vld4 !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid cyc%0d: got %b want 1", cyc, vld4); end
      if (vld4 && q.size() > 0) begin
        e = q.pop_front();
        emitted++;
        n_vec++; if (o4w !== e.e4) begin n_err++; $display("FAIL bp_order4: got %h want %h", o4w, e.e4); end
        n_vec++; if (o8 !== e.e8) begin n_err++; $display("FAIL bp_order8: got %h want %h", o8, e.e8); end
      end
      if (in_valid && rdy4) begin push_exp(bp[i], bpi[i]); i++; end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (emitted !== 5) begin n_err++; $display("FAIL bp_emitted: got %0d want 5", emitted); end
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", vld4); end
    q.delete();
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    @(negedge clk);
    set_all(rand_blk()); in_inverse = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    set_all(rand_blk()); in_inverse = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_two();
    n_vec++; if (rdy4 !== 1'b0) begin n_err++; $display("FAIL mid_two_ready: got %b want 0", rdy4); end
    #2 n_rst = 1'b0;
    #1;
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", vld4); end
    n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", rdy4); end
    n_vec++; if (o4 !== '0) begin n_err++; $display("FAIL mid_rst_data4: got %h want 0", o4); end
    n_vec++; if (o8 !== '0) begin n_err++; $display("FAIL mid_rst_data8: got %h want 0", o8); end
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (vld4 !== 1'b0) begin n_err++; $display("FAIL mid_rst_stale cyc%0d: got %b want 0", cyc, vld4); end
    end
  endtask

  task automatic test_clear();
    fill_two();
    clear = 1'b1;
    set_all(rand_blk()); in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL clr_two_valid: got %b want 0", vld4); end
    n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL clr_two_ready: got %b want 1", rdy4); end
    repeat (2) @(negedge clk);
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL clr_two_drop: got %b want 0", vld4); end
    // Clear in ONE with an acceptable offer: the offer must be dropped too.
    out_ready = 1'b0;
    set_all(rand_blk()); in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    set_all(rand_blk());
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL clr_one_valid: got %b want 0", vld4); end
    repeat (2) @(negedge clk);
    n_vec++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL clr_one_drop: got %b want 0", vld4); end
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    int emitted = 0;
    exp_t e;
    q.delete();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    for (int cyc = 0; cyc < 8000 && emitted < 1000; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inverse = 1'($urandom_range(0, 1));
        set_all(rand_blk());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (vld4 && out_ready) begin
        emitted++;
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_underflow: got emit want none");
        end else begin
          e = q.pop_front();
          if (o4w !== e.e4 || o6w !== e.e6 || o8 !== e.e8) begin
            n_err++;
            $display("FAIL rand_data #%0d: got %h want %h", emitted, o8, e.e8);
            $display("FAIL rand_data4/6 #%0d: got %h %h want %h %h", emitted, o4, o6,
                     e.e4[0:127], e.e6[0:191]);
          end
        end
      end
      if (in_valid && rdy4) push_exp(d4, in_inverse);
      hold = in_valid && !rdy4;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (emitted !== 1000) begin n_err++; $display("FAIL rand_budget: got %0d want 1000", emitted); end
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
    n_vec++; if (cnt4 !== 32'd1000) begin n_err++; $display("FAIL cnt4: got %0d want 1000", cnt4); end
    n_vec++; if (cnt8 !== 32'd1000) begin n_err++; $display("FAIL cnt8: got %0d want 1000", cnt8); end
`endif
    q.delete();
  endtask

`ifdef SHIFT_ROWS_PIPE_COUNT_EN
  task automatic test_count_wrap();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    force dut4.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut4.cnt_q;
    set_all(rand_blk()); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (cnt4 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_preset: got %h want ffffffff", cnt4); end
    @(negedge clk);
    n_vec++; if (cnt4 !== 32'd0) begin n_err++; $display("FAIL cnt_wrap: got %h want 0", cnt4); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips();
    test_round_trip();
    test_back_pressure();
    test_reset_mid();
    test_clear();
    test_random();
`ifdef SHIFT_ROWS_PIPE_COUNT_EN
    test_count_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered Rijndael ShiftRows / InvShiftRows stage with valid/ready handshake on both sides.
- Generalises the fixed 128-bit combinational row shift to block widths of NB columns (NB = 4, 6 or 8).
- Adds a per-transaction inverse mode for the decrypt datapath.
- Sits between the SubBytes and MixColumns stages of the pipelined AES round datapath; a 2-entry skid buffer sustains full throughput without a combinational ready path.

Parameters:
- NB, 4, state columns. Block width W = 32*NB. Legal values are 4, 6 and 8; any other value is an elaboration-time $fatal.

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; drops all buffered blocks.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  stage can accept a block.
- in_inverse  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with in_data.
- in_data  input  W  state block [0:W-1]; byte k = bits [8k:8k+7]; byte k is row k%4, column k/4 (column-major).
- out_valid  output  1  output block valid.
- out_ready  input  1  downstream accepts.
- out_data  output  W  shifted block, same byte layout.

Behaviour:
- Row offsets s(r), rows 0..3:
  - NB=4: 0,1,2,3
  - NB=6: 0,1,2,3
  - NB=8: 0,1,3,4
- Forward mode: out byte (r,c) = in byte (r, (c+s(r)) mod NB).
- Inverse mode: out byte (r,c) = in byte (r, (c-s(r)+NB) mod NB).
- Row 0 passes unchanged. Mod-NB wrap is resolved at elaboration; no runtime arithmetic.
- The shift is applied combinationally at the input. Buffered data is stored already shifted.
- Storage is a main register (drives out_data) plus a skid register. Occupancy state machine:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - TWO (2): out_valid=1, in_ready=0.
- Handshake events: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE (load main).
  - ONE: accept & !emit -> TWO (load skid).
  - ONE: accept & emit -> ONE (load main with the new block).
  - ONE: !accept & emit -> EMPTY.
  - TWO: emit -> ONE (skid moves to main).
  - TWO: no accept is possible because in_ready=0.
- Latency 1 cycle (in_valid at edge N -> out_valid after edge N). Throughput 1 block/cycle while out_ready=1.
- in_ready and out_valid are pure register outputs; no combinational in->out path.
- Order is preserved strictly FIFO. in_inverse applies only to the block it accompanies, so mixed-mode streams are legal.
- out_data is stable while out_valid=1 and out_ready=0 (AXI-style hold).
- Upstream must hold in_data/in_inverse stable while in_valid=1 and in_ready=0; the bench asserts this.
- clear: next state EMPTY. clear overrides accept/emit in the same cycle, and a block offered that cycle is dropped. Data registers are not cleared.
- Reset (n_rst=0, async, also mid-transfer): state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0.
- in_ready becomes 1 in the first cycle after reset deassertion.

Optional Feature:
- Macro SHIFT_ROWS_PIPE_COUNT_EN.
- Defined:
  - Adds output port blk_count, 32 bits: count of emitted blocks.
  - Reset and clear drive it to 0; it wraps 0xFFFFFFFF -> 0.
  - Increments once per emit cycle.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 App. B, NB=4, in_inverse=0: in = d42711ae e0bf98f1 b8b45de5 1e415230 -> out = d4bf5d30 e0b452ae b84111f1 1e2798e5, one cycle after accept.
- NB=4, in bytes 00..0f, in_inverse=0 -> out 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. Feed that result back with in_inverse=1 -> out bytes 00..0f.
- NB=8, bytes 00..1f, forward: row 2 output columns = in columns 3,4,5,6,7,0,1,2; row 3 = columns 4..7,0..3. Round-trip through inverse -> identity. Repeat the round-trip for NB=6 -> identity.
- Back-pressure sequence:
  - Stream 5 blocks with out_ready=0: in_ready drops after 2 accepts.
  - Raise out_ready: 5 blocks emerge in order, 1 per cycle, out_data stable while stalled.
- Reset mid-operation: n_rst pulsed low while in state TWO -> out_valid=0 and in_ready=1 immediately, out_data=0, no stale block emitted afterwards. clear asserted in state TWO together with in_valid=1 -> state EMPTY next cycle, offered block dropped.
- With SHIFT_ROWS_PIPE_COUNT_EN: 1000 random mixed-mode blocks with random out_ready -> blk_count=1000. Force counter to 0xFFFFFFFF, emit 1 block -> blk_count=0.
